// File: rtl/dct_mem_pkg.sv
// Shared definitions for the DCT memory sequencer.
//   seq_state_t  : sequencer state encoding
//   DEF_*        : default widths, block length and DCT latency
//   pipe_depth() : depth of the read-valid tracking pipeline
package dct_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   localparam int DEF_IN_W    = 128;
   localparam int DEF_OUT_W   = 192;
   localparam int DEF_RA_W    = 10;
   localparam int DEF_CA_W    = 4;
   localparam int DEF_BLK_LEN = 16;
   localparam int DEF_DCT_LAT = 4;

   // One cycle of SRAM read latency plus the x_n register sit ahead of the DCT.
   function automatic int pipe_depth(input int dct_lat);
      return dct_lat + 2;
   endfunction

endpackage

// File: rtl/dct_mem_sequencer_if.sv
// Bus bundle between the sequencer, the two SRAM macros and the DCT unit.
//   master : sequencer side (drives enables, addresses, x_n, flag, write data)
//   slave  : environment side (drives start/mode, read data, DCT output)
interface dct_mem_sequencer_if
   import dct_mem_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int RA_W  = DEF_RA_W,
   parameter int CA_W  = DEF_CA_W
);
   logic             start;
   logic             mode;
   logic             busy;
   logic             done;
   logic             NCE_IN;
   logic             NWRT_IN;
   logic [RA_W-1:0]  RA_IN;
   logic [CA_W-1:0]  CA_IN;
   logic [IN_W-1:0]  mem_rdata;
   logic [IN_W-1:0]  x_n;
   logic             flag;
   logic [OUT_W-1:0] X_k;
   logic             NCE_OUT;
   logic             NWRT_OUT;
   logic [RA_W-1:0]  RA_OUT;
   logic [CA_W-1:0]  CA_OUT;
   logic [OUT_W-1:0] mem_wdata;

   modport master (
      input  start, mode, mem_rdata, X_k,
      output busy, done, NCE_IN, NWRT_IN, RA_IN, CA_IN, x_n, flag,
             NCE_OUT, NWRT_OUT, RA_OUT, CA_OUT, mem_wdata
   );

   modport slave (
      output start, mode, mem_rdata, X_k,
      input  busy, done, NCE_IN, NWRT_IN, RA_IN, CA_IN, x_n, flag,
             NCE_OUT, NWRT_OUT, RA_OUT, CA_OUT, mem_wdata
   );
endinterface

// File: rtl/dct_addr_gen.sv
// Saturating word counter with row/column address split.
//   clk, reset : clock, async active-low reset
//   i_clr      : clear count to 0 (wins over i_inc)
//   i_inc      : advance count, holds at NUM_WORDS-1
//   i_mode     : 0 = CA fastest, 1 = RA fastest (only when RA_W == CA_W)
//   o_cnt      : current word index
//   o_ra, o_ca : address derived from o_cnt
module dct_addr_gen
   import dct_mem_pkg::*;
#(
   parameter int RA_W      = DEF_RA_W,
   parameter int CA_W      = DEF_CA_W,
   parameter int NUM_WORDS = 2**(RA_W+CA_W)
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_clr,
   input  logic                   i_inc,
   input  logic                   i_mode,
   output logic [RA_W+CA_W-1:0]   o_cnt,
   output logic [RA_W-1:0]        o_ra,
   output logic [CA_W-1:0]        o_ca
);
   localparam int               CNT_W        = RA_W + CA_W;
   localparam logic [CNT_W-1:0] LAST         = CNT_W'(NUM_WORDS - 1);
   localparam logic             TRANSPOSE_OK = 1'(RA_W == CA_W);

   logic [CNT_W-1:0] r_cnt;
   logic             w_mode;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         r_cnt <= '0;
      else if (i_clr)                     r_cnt <= '0;
      else if (i_inc && (r_cnt != LAST))  r_cnt <= r_cnt + 1'b1;
   end

   // Transposed order only makes sense for a square array.
   assign w_mode = i_mode & TRANSPOSE_OK;
   assign o_cnt  = r_cnt;

   always_comb begin
      o_ra = r_cnt[CA_W +: RA_W];
      o_ca = r_cnt[CA_W-1:0];
      if (w_mode) begin
         o_ra = r_cnt[RA_W-1:0];
         o_ca = r_cnt[RA_W +: CA_W];
      end
   end
endmodule

// File: rtl/dct_mem_sequencer.sv
// Streams one frame from the input SRAM through the DCT unit into the
// output SRAM, with latency-aligned write addressing.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : start/mode/busy/done handshake, input SRAM read port,
//           DCT x_n/flag/X_k, output SRAM write port
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for start, all enables high
// ST_READ  | one input read per cycle, rc = 0..NUM_WORDS-1
// ST_DRAIN | reads finished, writes still emerging from pipe
// ST_DONE  | done pulse, back to idle next cycle
module dct_mem_sequencer
   import dct_mem_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int RA_W      = DEF_RA_W,
   parameter int CA_W      = DEF_CA_W,
   parameter int BLK_LEN   = DEF_BLK_LEN,
   parameter int DCT_LAT   = DEF_DCT_LAT,
   parameter int NUM_WORDS = 2**(RA_W+CA_W)
)(
   input  logic                 clk,
   input  logic                 reset,
   dct_mem_sequencer_if.master  bus
);
   localparam int               L        = pipe_depth(DCT_LAT);
   localparam int               CNT_W    = RA_W + CA_W;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] BLK_MASK = CNT_W'(BLK_LEN - 1);

   seq_state_t       r_state;
   logic             r_mode;
   logic             r_busy;
   logic             r_done;
   logic             r_nce_in;
   logic             r_nce_out;
   logic             r_flag;
   logic             r_blk_first;
   logic             r_last_wr;
   logic [L-1:0]     r_vpipe;
   logic [IN_W-1:0]  r_x_n;
   logic [OUT_W-1:0] r_wdata;
   logic [RA_W-1:0]  r_ra_out;
   logic [CA_W-1:0]  r_ca_out;

   logic             w_start_ok;
   logic             w_reading;
   logic             w_emerge;
   logic [CNT_W-1:0] w_rc;
   logic [CNT_W-1:0] w_wc;
   logic [RA_W-1:0]  w_ra_rd;
   logic [CA_W-1:0]  w_ca_rd;
   logic [RA_W-1:0]  w_ra_wr;
   logic [CA_W-1:0]  w_ca_wr;

   assign w_start_ok = (r_state == ST_IDLE) && bus.start;
   assign w_reading  = (r_state == ST_READ);
   assign w_emerge   = r_vpipe[L-1];

   dct_addr_gen #(.RA_W(RA_W), .CA_W(CA_W), .NUM_WORDS(NUM_WORDS)) u_rd_gen (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_start_ok),
      .i_inc  (w_reading),
      .i_mode (r_mode),
      .o_cnt  (w_rc),
      .o_ra   (w_ra_rd),
      .o_ca   (w_ca_rd)
   );

   dct_addr_gen #(.RA_W(RA_W), .CA_W(CA_W), .NUM_WORDS(NUM_WORDS)) u_wr_gen (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_start_ok),
      .i_inc  (w_emerge),
      .i_mode (1'b0),
      .o_cnt  (w_wc),
      .o_ra   (w_ra_wr),
      .o_ca   (w_ca_wr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_nce_in    <= 1'b1;
         r_nce_out   <= 1'b1;
         r_flag      <= 1'b0;
         r_blk_first <= 1'b0;
         r_last_wr   <= 1'b0;
         r_vpipe     <= '0;
         r_x_n       <= '0;
         r_wdata     <= '0;
         r_ra_out    <= '0;
         r_ca_out    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state  <= ST_READ;
                  r_mode   <= bus.mode;
                  r_busy   <= 1'b1;
                  r_nce_in <= 1'b0;
               end
            end
            ST_READ: begin
               if (w_rc == LAST) begin
                  r_state  <= ST_DRAIN;
                  r_nce_in <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (r_last_wr) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase

         r_x_n   <= bus.mem_rdata;
         r_vpipe <= {r_vpipe[L-2:0], w_reading};

         // Block-start marker follows the read by one cycle so the toggle
         // lands together with the word in x_n.
         r_blk_first <= w_reading && ((w_rc & BLK_MASK) == '0);
         if (r_blk_first) r_flag <= ~r_flag;

         r_nce_out <= ~w_emerge;
         r_last_wr <= w_emerge && (w_wc == LAST);
         if (w_emerge) begin
            r_wdata  <= bus.X_k;
            r_ra_out <= w_ra_wr;
            r_ca_out <= w_ca_wr;
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.NCE_IN    = r_nce_in;
   assign bus.NWRT_IN   = 1'b1;
   assign bus.RA_IN     = w_ra_rd;
   assign bus.CA_IN     = w_ca_rd;
   assign bus.x_n       = r_x_n;
   assign bus.flag      = r_flag;
   assign bus.NCE_OUT   = r_nce_out;
   assign bus.NWRT_OUT  = r_nce_out;
   assign bus.RA_OUT    = r_ra_out;
   assign bus.CA_OUT    = r_ca_out;
   assign bus.mem_wdata = r_wdata;
endmodule
